// File: rtl/adda_pkg.sv
// Shared types and defaults for the ADC -> DAC streaming block.
package adda_pkg;

  localparam int ADDA_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_DELAY = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

endpackage

// File: rtl/adda_delay_ram.sv
// Single-clock simple dual-port delay memory with registered read; contents are not reset.
module adda_delay_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adda_stream.sv
// AD9280 -> AD9708 streaming path: pass / delay / ramp / hold, plus peak tracker.
// Optional feature macro: ADDA_PEAK_EN (peak detector with clear; otherwise o_peak = last sample).
module adda_stream
  import adda_pkg::*;
#(
  parameter int DATA_W = ADDA_DATA_W,
  parameter int DIV    = 2,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_ad_data,
  output logic              o_ad_clk,
  output logic              o_da_clk,
  output logic [DATA_W-1:0] o_da_data,
  input  logic [1:0]        i_mode,
  input  logic [AW-1:0]     i_delay,
  input  logic              i_peak_clr,
  output logic [DATA_W-1:0] o_peak,
  output logic              o_valid
);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ad_clk_q, ad_clk_d, da_clk_q, da_clk_d;
  logic              stb_s, sample_q, sample_d, valid_q, valid_d;
  logic [DATA_W-1:0] ad_q, ad_d, da_data_q, da_data_d, ramp_q, ramp_d;
  mode_e             mode_q, mode_d;
  logic              dly_zero_q, dly_zero_d, dly_ok_q, dly_ok_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW:0]       fill_q, fill_d;
  logic [DATA_W-1:0] rd_data_s;

  assign stb_s = (cnt_q == CW'(DIV - 1));

  adda_delay_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (i_clk),
    .we    (stb_s),
    .waddr (wp_q),
    .wdata (i_ad_data),
    .re    (stb_s),
    .raddr (wp_q - i_delay),
    .rdata (rd_data_s)
  );

  // Converter clocks, capture and per-sample bookkeeping.
  always_comb begin
    cnt_d      = stb_s ? {CW{1'b0}} : cnt_q + CW'(1);
    ad_clk_d   = (cnt_d < CW'(DIV / 2));
    da_clk_d   = ~ad_clk_q;
    sample_d   = stb_s;
    ad_d       = ad_q;
    mode_d     = mode_q;
    dly_zero_d = dly_zero_q;
    dly_ok_d   = dly_ok_q;
    wp_d       = wp_q;
    fill_d     = fill_q;
    ramp_d     = ramp_q;
    if (stb_s) begin
      ad_d       = i_ad_data;
      mode_d     = mode_e'(i_mode);
      dly_zero_d = (i_delay == {AW{1'b0}});
      // fill_q counts samples written before this one, so the delayed sample exists iff fill >= delay.
      dly_ok_d   = (fill_q >= {1'b0, i_delay});
      wp_d       = wp_q + AW'(1);
      fill_d     = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + (AW+1)'(1);
      ramp_d     = ramp_q + DATA_W'(1);
    end else begin
      ad_d = ad_q;
    end
  end

  // Output stage, one cycle after the strobe; ramp_q has already advanced, so step back by one.
  always_comb begin
    valid_d   = sample_q;
    da_data_d = da_data_q;
    if (sample_q) begin
      case (mode_q)
        MODE_PASS:  da_data_d = ad_q;
        MODE_DELAY: da_data_d = dly_zero_q ? ad_q : (dly_ok_q ? rd_data_s : {DATA_W{1'b0}});
        MODE_RAMP:  da_data_d = ramp_q - DATA_W'(1);
        MODE_HOLD:  da_data_d = da_data_q;
        default:    da_data_d = da_data_q;
      endcase
    end else begin
      da_data_d = da_data_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= {CW{1'b0}};
      ad_clk_q   <= 1'b1;
      da_clk_q   <= 1'b0;
      sample_q   <= 1'b0;
      valid_q    <= 1'b0;
      ad_q       <= {DATA_W{1'b0}};
      da_data_q  <= {DATA_W{1'b0}};
      ramp_q     <= {DATA_W{1'b0}};
      mode_q     <= MODE_PASS;
      dly_zero_q <= 1'b0;
      dly_ok_q   <= 1'b0;
      wp_q       <= {AW{1'b0}};
      fill_q     <= {(AW+1){1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      ad_clk_q   <= ad_clk_d;
      da_clk_q   <= da_clk_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ad_q       <= ad_d;
      da_data_q  <= da_data_d;
      ramp_q     <= ramp_d;
      mode_q     <= mode_d;
      dly_zero_q <= dly_zero_d;
      dly_ok_q   <= dly_ok_d;
      wp_q       <= wp_d;
      fill_q     <= fill_d;
    end
  end

  assign o_ad_clk  = ad_clk_q;
  assign o_da_clk  = da_clk_q;
  assign o_da_data = da_data_q;
  assign o_valid   = valid_q;

`ifdef ADDA_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d;

  // Peak tracker; a clear coinciding with a strobe restarts from the captured sample.
  always_comb begin
    peak_d = peak_q;
    if (stb_s) begin
      if (i_peak_clr || (i_ad_data > peak_q)) begin
        peak_d = i_ad_data;
      end else begin
        peak_d = peak_q;
      end
    end else if (i_peak_clr) begin
      peak_d = {DATA_W{1'b0}};
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= {DATA_W{1'b0}};
    end else begin
      peak_q <= peak_d;
    end
  end

  assign o_peak = peak_q;
`else
  logic unused_peak_clr_s;
  assign unused_peak_clr_s = i_peak_clr;
  assign o_peak            = ad_q;
`endif

endmodule

// File: tb/tb_adda_stream.sv
// Directed bench for adda_stream (DATA_W=8, DIV=2, DEPTH=256); ADDA_PEAK_EN selects peak expectations.
module tb_adda_stream;

`ifdef ADDA_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ad_data = 8'h00;
  logic       ad_clk, da_clk, valid;
  logic [7:0] da_data, peak;
  logic [1:0] mode = 2'd0;
  logic [7:0] delay = 8'd0;
  logic       peak_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] outq[$];

  adda_stream dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ad_data  (ad_data),
    .o_ad_clk   (ad_clk),
    .o_da_clk   (da_clk),
    .o_da_data  (da_data),
    .i_mode     (mode),
    .i_delay    (delay),
    .i_peak_clr (peak_clr),
    .o_peak     (peak),
    .o_valid    (valid)
  );

  always #20 clk = ~clk;

  // Collect every DAC update.
  always @(negedge clk) begin
    if (rst_n && valid) outq.push_back(da_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start and end at the negedge just after a strobe edge (or reset release).
  task automatic sample(input logic [7:0] d);
    ad_data = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [7:0] dl);
    @(negedge clk);
    rst_n = 1'b0;
    mode  = m;
    delay = dl;
    repeat (2) @(negedge clk);
    outq.delete();
    rst_n = 1'b1;
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [7:0] exp);
    chk(tag, (idx < outq.size()) ? {24'd0, outq[idx]} : 32'hDEAD, {24'd0, exp});
  endtask

  initial begin
    // Reset values and mode 0 latency.
    ad_data = 8'h10;
    repeat (3) @(negedge clk);
    chk("rst_ad_clk", ad_clk, 1);
    chk("rst_da_clk", da_clk, 0);
    chk("rst_da_data", da_data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_peak", peak, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("p1_ad_clk", ad_clk, 0);
    chk("p1_da_clk", da_clk, 0);
    chk("p1_valid", valid, 0);
    @(negedge clk);
    chk("p2_ad_clk", ad_clk, 1);
    chk("p2_da_clk", da_clk, 1);
    chk("p2_valid", valid, 0);
    chk("p2_peak", peak, 8'h10);
    for (int i = 1; i < 8; i++) begin
      ad_data = 8'h10 + 8'(i);
      @(negedge clk);
      chk("pass_valid_hi", valid, 1);
      chk("pass_data", da_data, 8'h10 + 8'(i - 1));
      if (i == 1) begin
        chk("p3_ad_clk", ad_clk, 0);
        chk("p3_da_clk", da_clk, 0);
      end
      @(negedge clk);
      chk("pass_valid_lo", valid, 0);
    end

    // Mode 1, delay 3.
    do_reset(2'd1, 8'd3);
    for (int i = 0; i < 8; i++) sample(8'hA0 + 8'(i));
    repeat (2) @(negedge clk);
    chk("dly3_size", outq.size(), 8);
    for (int i = 0; i < 8; i++) chk_q("dly3", i, (i < 3) ? 8'h00 : 8'hA0 + 8'(i - 3));

    // Mode 1, delay DEPTH-1 across pointer wrap.
    do_reset(2'd1, 8'd255);
    for (int i = 0; i < 512; i++) sample(8'((i * 7) + 3));
    repeat (2) @(negedge clk);
    chk("dly255_size", outq.size(), 512);
    for (int i = 0; i < 512; i++) chk_q("dly255", i, (i < 255) ? 8'h00 : 8'(((i - 255) * 7) + 3));

    // Mode 2 ramp, 257 strobes.
    do_reset(2'd2, 8'd0);
    for (int i = 0; i < 257; i++) sample(8'hC3);
    repeat (2) @(negedge clk);
    chk("ramp_size", outq.size(), 257);
    for (int i = 0; i < 257; i++) chk_q("ramp", i, 8'(i));

    // Mode 3 hold after one pass sample.
    do_reset(2'd0, 8'd0);
    sample(8'h55);
    mode = 2'd3;
    sample(8'h66);
    sample(8'h77);
    repeat (2) @(negedge clk);
    chk("hold_size", outq.size(), 3);
    for (int i = 0; i < 3; i++) chk_q("hold", i, 8'h55);

    // Peak tracking and clear.
    do_reset(2'd0, 8'd0);
    sample(8'h20);
    sample(8'h80);
    sample(8'h40);
    chk("peak_max", peak, PEAK_EN ? 8'h80 : 8'h40);
    ad_data = 8'h30;
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("peak_clr_stb", peak, 8'h30);
    ad_data  = 8'h10;
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("peak_clr_only", peak, PEAK_EN ? 8'h00 : 8'h30);
    @(negedge clk);
    chk("peak_after_clr", peak, 8'h10);

    // Reset mid-stream in mode 1.
    do_reset(2'd1, 8'd3);
    for (int i = 0; i < 5; i++) sample(8'hC0 + 8'(i));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_ad_clk", ad_clk, 1);
    chk("mid_da_clk", da_clk, 0);
    chk("mid_da_data", da_data, 0);
    chk("mid_valid", valid, 0);
    chk("mid_peak", peak, 0);
    repeat (2) @(negedge clk);
    outq.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sample(8'hB0 + 8'(i));
    repeat (2) @(negedge clk);
    chk("mid_size", outq.size(), 4);
    for (int i = 0; i < 4; i++) chk_q("mid_dly", i, (i < 3) ? 8'h00 : 8'hB0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
